// File: rtl/sqrt_seq_pkg.sv
// Shared types for the sequential square-root block: FSM state encoding and
// the iteration-counter width helper.
package sqrt_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // The counter runs N-1 down to 0, so clog2(N) bits always suffice.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// Valid/ready handshake bundle for sqrt_seq: radicand in, root/remainder out.
interface sqrt_seq_if #(parameter int N = 8);

  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_root;
  logic [N:0]     out_rem;
  logic           out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_root, out_rem, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_root, out_rem, out_sat
  );

endinterface

// File: rtl/sqrt_seq_step.sv
// One restoring square-root iteration: bring down the next radicand bit pair,
// try subtracting {root,01}, and shift the resulting root bit in.
module sqrt_seq_step #(parameter int N = 8) (
  input  logic [N+1:0] rem_in,
  input  logic [N-1:0] root_in,
  input  logic [1:0]   pair,
  output logic [N+1:0] rem_out,
  output logic [N-1:0] root_out
);

  logic [N+1:0] rem_sh;
  logic [N+1:0] trial;
  logic         ge;

  // The shifted-out top bits of rem_in are always zero since rem <= 2*root.
  always_comb begin
    rem_sh   = (rem_in << 2) | {{N{1'b0}}, pair};
    trial    = {root_in, 2'b01};
    ge       = (rem_sh >= trial);
    rem_out  = ge ? (rem_sh - trial) : rem_sh;
    root_out = {root_in[N-2:0], ge};
  end

endmodule

// File: rtl/sqrt_seq.sv
// Sequential integer square root, one root bit per clock with valid/ready on both sides.
// Define SQRT_ROUND_EN to round out_root to nearest (saturating, flagged on out_sat).
module sqrt_seq
  import sqrt_seq_pkg::*;
#(
  parameter int N = 8
) (
  input logic        clk,
  input logic        rst_n,
  sqrt_seq_if.slave  bus
);

  localparam int CW = cnt_width(N);

  state_t         state, state_nxt;
  logic [2*N-1:0] x;
  logic [N+1:0]   rem_w, rem_nxt;
  logic [N-1:0]   root_w, root_nxt, root_fin;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   root_q;
  logic [N:0]     rem_q;
  logic           accept;
  logic           last;

  assign bus.in_ready  = (state == S_IDLE) && rst_n;
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_root  = root_q;
  assign bus.out_rem   = rem_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (state == S_BUSY) && (cnt == '0);

  sqrt_seq_step #(.N(N)) u_step (
    .rem_in   (rem_w),
    .root_in  (root_w),
    .pair     (x[2*N-1 -: 2]),
    .rem_out  (rem_nxt),
    .root_out (root_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SQRT_ROUND_EN
  logic round_up;
  logic sat_q;

  // rem > root means x >= r^2+r+1 > (r+0.5)^2, so round up unless r is already max.
  always_comb begin
    round_up = (rem_nxt > {2'b00, root_nxt});
    root_fin = root_nxt;
    if (round_up && !(&root_nxt)) root_fin = root_nxt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sat_q <= 1'b0;
    else if (last) sat_q <= round_up && (&root_nxt);
  end

  assign bus.out_sat = sat_q;
`else
  assign root_fin    = root_nxt;
  assign bus.out_sat = 1'b0;
`endif

  // Datapath: load on accept, iterate while busy, capture the result on the last pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      rem_w  <= '0;
      root_w <= '0;
      cnt    <= '0;
      root_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      x      <= bus.in_data;
      rem_w  <= '0;
      root_w <= '0;
      cnt    <= CW'(N - 1);
    end else if (state == S_BUSY) begin
      x      <= x << 2;
      rem_w  <= rem_nxt;
      root_w <= root_nxt;
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        root_q <= root_fin;
        rem_q  <= (N+1)'(rem_nxt);
      end
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// Self-checking bench for sqrt_seq: directed boundary/handshake scenarios plus
// random radicands checked against an arithmetic square-root model.
module tb_sqrt_seq;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sqrt_seq_if #(.N(N)) bus ();

  sqrt_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: largest r with r*r <= x, found by plain search.
  task automatic model(input logic [2*N-1:0] x, output logic [N-1:0] root,
                       output logic [N:0] rem, output logic sat);
    longint r;
    longint xv;
    xv  = longint'(x);
    r   = 0;
    while ((r + 1) * (r + 1) <= xv) r++;
    rem = (N+1)'(xv - r * r);
    sat = 1'b0;
`ifdef SQRT_ROUND_EN
    if ((xv - r * r) > r) begin
      if (r == (1 << N) - 1) sat = 1'b1;
      else                   r   = r + 1;
    end
`endif
    root = N'(r);
  endtask

  // One full transaction: offer, wait for accept, measure latency, check, retire.
  task automatic apply_stimulus(input logic [2*N-1:0] x, input string tag);
    int             waitc;
    int             lat;
    logic [N-1:0]   er;
    logic [N:0]     erem;
    logic           es;
    model(x, er, erem, es);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    waitc = 0;
    while (!bus.in_ready && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    check_output({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({tag, "_latency"}, 32'(lat), 32'(N));
    check_output({tag, "_root"}, 32'(bus.out_root), 32'(er));
    check_output({tag, "_rem"}, 32'(bus.out_rem), 32'(erem));
    check_output({tag, "_sat"}, 32'(bus.out_sat), 32'(es));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_output({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [N-1:0]   er;
    logic [N:0]     erem;
    logic           es;
    logic [2*N-1:0] q[$];
    logic [2*N-1:0] xq;
    int             last_acc;
    int             acc;
    int             r;

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_root", 32'(bus.out_root), 32'd0);
    check_output("rst_out_rem", 32'(bus.out_rem), 32'd0);
    check_output("rst_out_sat", 32'(bus.out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_in_ready", 32'(bus.in_ready), 32'd1);

    apply_stimulus(16'd144, "sq144");
    apply_stimulus(16'd143, "x143");
    apply_stimulus(16'd0, "zero");
    apply_stimulus(16'hFFFF, "max");
    apply_stimulus(16'd1, "one");
    apply_stimulus(16'd65024, "x65024");

    // Backpressure: result held while out_ready is low, new radicand ignored.
    $display("[TB] backpressure scenario");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd200;
    @(posedge clk);
    #1;
    bus.in_data = 16'd9999;
    for (int i = 0; i < 40 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_valid", 32'(bus.out_valid), 32'd1);
      check_output("bp_root", 32'(bus.out_root), 32'd14);
      check_output("bp_rem", 32'(bus.out_rem), 32'd4);
      check_output("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_output("bp_retired", 32'(bus.out_valid), 32'd0);
    check_output("bp_not_accepted", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of an operation discards it.
    $display("[TB] mid-operation reset scenario");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_output("mid_rst_root", 32'(bus.out_root), 32'd0);
    check_output("mid_rst_rem", 32'(bus.out_rem), 32'd0);
    check_output("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(16'd1000, "after_rst");

    // Random radicands, biased toward perfect squares and their neighbours.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, (1 << N) - 1));
      case ($urandom_range(0, 3))
        0:       xq = 16'(r * r);
        1:       xq = (r == 0) ? 16'd0 : 16'(r * r - 1);
        default: xq = 16'($urandom);
      endcase
      apply_stimulus(xq, "rand");
    end

    // Back-to-back offers with the consumer always ready.
    $display("[TB] throughput scenario");
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'($urandom);
    last_acc = -1;
    acc      = 0;
    for (int cyc = 0; cyc < 100 && acc < 5; cyc++) begin
      if (bus.out_valid) begin
        check_output("tp_queue", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          model(q.pop_front(), er, erem, es);
          check_output("tp_root", 32'(bus.out_root), 32'(er));
          check_output("tp_rem", 32'(bus.out_rem), 32'(erem));
        end
      end
      if (bus.in_ready) begin
        if (last_acc >= 0) check_output("tp_gap", 32'(cyc - last_acc), 32'(N + 2));
        last_acc = cyc;
        q.push_back(bus.in_data);
        acc++;
      end else begin
        bus.in_data = 16'($urandom);
      end
      if (acc < 5) @(negedge clk);
    end
    check_output("tp_accepts", 32'(acc), 32'd5);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
    check_output("tp_last_valid", 32'(bus.out_valid), 32'd1);
    if (q.size() > 0) begin
      model(q.pop_front(), er, erem, es);
      check_output("tp_last_root", 32'(bus.out_root), 32'(er));
      check_output("tp_last_rem", 32'(bus.out_rem), 32'(erem));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
